// File: rtl/hyper_pipe_pkg.sv
// rtl/hyper_pipe_pkg.sv - shared types and default constants for hyper_pipe_stream
//
// Holds the default parameter values, the default-width per-channel beat
// struct and the packet-framing monitor state encoding.
package hyper_pipe_pkg;

  localparam int unsigned HP_NUM_CH_DEF     = 4;
  localparam int unsigned HP_DATA_W_DEF     = 512;
  localparam int unsigned HP_EMPTY_W_DEF    = 6;
  localparam int unsigned HP_NUM_STAGES_DEF = 2;
  localparam int unsigned HP_CNT_W_DEF      = 32;

  // Field order is shared with the top-level beat type so a flat
  // {data, sop, eop, empty} concatenation maps directly onto it.
  typedef struct packed {
    logic [HP_DATA_W_DEF-1:0]  data;
    logic                      sop;
    logic                      eop;
    logic [HP_EMPTY_W_DEF-1:0] empty;
  } hp_beat_t;

  typedef enum logic {
    FRM_IDLE   = 1'b0,
    FRM_IN_PKT = 1'b1
  } hp_frm_state_e;

endpackage

// File: rtl/hyper_pipe_skid.sv
// rtl/hyper_pipe_skid.sv - single-channel, single-stage skid register
//
// Purpose: one elastic stage with a main slot and a skid slot. in_ready_o is
// a pure register output, so there is no combinational path from
// out_ready_i back to in_ready_o.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   in_valid_i / in_ready_o    upstream handshake
//   in_beat_i                  upstream beat
//   out_valid_o / out_ready_i  downstream handshake
//   out_beat_o                 downstream beat (main slot)
module hyper_pipe_skid
  import hyper_pipe_pkg::*;
#(
  parameter type beat_t = hp_beat_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  input  beat_t in_beat_i,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output beat_t out_beat_o
);

  logic  m_valid_q, m_valid_d;
  logic  s_valid_q, s_valid_d;
  beat_t m_beat_q,  m_beat_d;
  beat_t s_beat_q,  s_beat_d;
  logic  in_fire;
  logic  m_free;

  assign in_ready_o  = ~s_valid_q;
  assign out_valid_o = m_valid_q;
  assign out_beat_o  = m_beat_q;

  assign in_fire = in_valid_i & ~s_valid_q;
  assign m_free  = ~m_valid_q | out_ready_i;

  always_comb begin
    m_valid_d = m_valid_q;
    m_beat_d  = m_beat_q;
    s_valid_d = s_valid_q;
    s_beat_d  = s_beat_q;
    if (m_free) begin
      // The skid slot is only ever occupied while main is full, and the
      // input is blocked while it is, so the skid beat always goes first.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_beat_d  = s_beat_q;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = in_fire;
        if (in_fire) begin
          m_beat_d = in_beat_i;
        end
      end
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_beat_d  = in_beat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  // Payload registers carry no reset; they are only observed behind valid.
  always_ff @(posedge clk_i) begin
    m_beat_q <= m_beat_d;
    s_beat_q <= s_beat_d;
  end

endmodule

// File: rtl/hyper_pipe_stream.sv
// rtl/hyper_pipe_stream.sv - multi-channel elastic pipeline with framing monitor
//
// Purpose: carries NUM_CH independent packet streams through NUM_STAGES skid
// stages each, flags framing errors seen on accepted input beats, and
// (optionally) counts delivered beats, packets and output stall cycles.
// Optional feature macro: HYPER_PIPE_STREAM_STATS_EN adds CNT_W, stat_clear_i
// and the stat_*_o counter ports.
// Ports (per-channel fields concatenated with channel 0 in the LSBs):
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_*_i     upstream beats (data, sop, eop, empty)
//   out_valid_o/out_ready_i/out_*_o  downstream beats
//   frame_err_o                      sticky framing error per channel
//   err_clear_i                      synchronous clear of frame_err_o
//   stat_clear_i, stat_beats_o, stat_pkts_o, stat_stalls_o  (stats build)
module hyper_pipe_stream
  import hyper_pipe_pkg::*;
#(
  parameter int unsigned NUM_CH     = HP_NUM_CH_DEF,
  parameter int unsigned DATA_W     = HP_DATA_W_DEF,
  parameter int unsigned EMPTY_W    = HP_EMPTY_W_DEF,
  parameter int unsigned NUM_STAGES = HP_NUM_STAGES_DEF
`ifdef HYPER_PIPE_STREAM_STATS_EN
  ,
  parameter int unsigned CNT_W      = HP_CNT_W_DEF
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CH-1:0]         in_valid_i,
  output logic [NUM_CH-1:0]         in_ready_o,
  input  logic [NUM_CH*DATA_W-1:0]  in_data_i,
  input  logic [NUM_CH-1:0]         in_sop_i,
  input  logic [NUM_CH-1:0]         in_eop_i,
  input  logic [NUM_CH*EMPTY_W-1:0] in_empty_i,
  output logic [NUM_CH-1:0]         out_valid_o,
  input  logic [NUM_CH-1:0]         out_ready_i,
  output logic [NUM_CH*DATA_W-1:0]  out_data_o,
  output logic [NUM_CH-1:0]         out_sop_o,
  output logic [NUM_CH-1:0]         out_eop_o,
  output logic [NUM_CH*EMPTY_W-1:0] out_empty_o,
  input  logic                      err_clear_i,
`ifdef HYPER_PIPE_STREAM_STATS_EN
  input  logic                      stat_clear_i,
  output logic [NUM_CH*CNT_W-1:0]   stat_beats_o,
  output logic [NUM_CH*CNT_W-1:0]   stat_pkts_o,
  output logic [NUM_CH*CNT_W-1:0]   stat_stalls_o,
`endif
  output logic [NUM_CH-1:0]         frame_err_o
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Index s is the boundary in front of stage s; index NUM_STAGES is the output.
    logic  v [NUM_STAGES+1];
    logic  r [NUM_STAGES+1];
    beat_t b [NUM_STAGES+1];

    assign v[0]          = in_valid_i[c];
    assign b[0]          = {in_data_i[c*DATA_W +: DATA_W], in_sop_i[c], in_eop_i[c],
                            in_empty_i[c*EMPTY_W +: EMPTY_W]};
    assign in_ready_o[c] = r[0];
    assign r[NUM_STAGES] = out_ready_i[c];

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stg
      hyper_pipe_skid #(.beat_t(beat_t)) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (v[s]),
        .in_ready_o  (r[s]),
        .in_beat_i   (b[s]),
        .out_valid_o (v[s+1]),
        .out_ready_i (r[s+1]),
        .out_beat_o  (b[s+1])
      );
    end

    assign out_valid_o[c]                    = v[NUM_STAGES];
    assign out_data_o[c*DATA_W +: DATA_W]    = b[NUM_STAGES].data;
    assign out_sop_o[c]                      = b[NUM_STAGES].sop;
    assign out_eop_o[c]                      = b[NUM_STAGES].eop;
    assign out_empty_o[c*EMPTY_W +: EMPTY_W] = b[NUM_STAGES].empty;

    // Framing monitor: watches accepted input beats only.
    hp_frm_state_e st_q, st_d;
    logic          err_q, err_d;
    logic          err_ev;
    logic          in_fire;

    assign in_fire        = in_valid_i[c] & r[0];
    assign frame_err_o[c] = err_q;

    always_comb begin
      st_d   = st_q;
      err_ev = 1'b0;
      if (in_fire) begin
        case (st_q)
          FRM_IDLE: begin
            if (!in_sop_i[c]) begin
              err_ev = 1'b1;
            end else if (!in_eop_i[c]) begin
              st_d = FRM_IN_PKT;
            end
          end
          FRM_IN_PKT: begin
            if (in_sop_i[c]) begin
              // Unterminated packet: flag it and treat this beat as a new start.
              err_ev = 1'b1;
              st_d   = in_eop_i[c] ? FRM_IDLE : FRM_IN_PKT;
            end else if (in_eop_i[c]) begin
              st_d = FRM_IDLE;
            end
          end
        endcase
      end
      // A new error outranks a simultaneous clear.
      err_d = err_ev ? 1'b1 : (err_clear_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q  <= FRM_IDLE;
        err_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        err_q <= err_d;
      end
    end

`ifdef HYPER_PIPE_STREAM_STATS_EN
    logic [CNT_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0] pkts_q,  pkts_d;
    logic [CNT_W-1:0] stalls_q, stalls_d;
    logic             out_fire;
    logic             out_stall;

    assign out_fire  = v[NUM_STAGES] & out_ready_i[c];
    assign out_stall = v[NUM_STAGES] & ~out_ready_i[c];

    always_comb begin
      beats_d  = beats_q;
      pkts_d   = pkts_q;
      stalls_d = stalls_q;
      if (stat_clear_i) begin
        beats_d  = '0;
        pkts_d   = '0;
        stalls_d = '0;
      end else begin
        // Counters stick at all-ones rather than wrapping.
        if (out_fire && beats_q != '1) begin
          beats_d = beats_q + CNT_W'(1);
        end
        if (out_fire && b[NUM_STAGES].eop && pkts_q != '1) begin
          pkts_d = pkts_q + CNT_W'(1);
        end
        if (out_stall && stalls_q != '1) begin
          stalls_d = stalls_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        beats_q  <= '0;
        pkts_q   <= '0;
        stalls_q <= '0;
      end else begin
        beats_q  <= beats_d;
        pkts_q   <= pkts_d;
        stalls_q <= stalls_d;
      end
    end

    assign stat_beats_o[c*CNT_W +: CNT_W]  = beats_q;
    assign stat_pkts_o[c*CNT_W +: CNT_W]   = pkts_q;
    assign stat_stalls_o[c*CNT_W +: CNT_W] = stalls_q;
`endif
  end

endmodule

// File: tb/tb_hyper_pipe_stream.sv
// tb/tb_hyper_pipe_stream.sv - self-checking bench for hyper_pipe_stream
module tb_hyper_pipe_stream;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 32;
  localparam int EMPTY_W    = 6;
  localparam int NUM_STAGES = 2;
  localparam int CNT_W      = 16;
  localparam int WW         = DATA_W + EMPTY_W + 2;

  typedef logic [WW-1:0] word_t;  // {sop, eop, empty, data}

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH-1:0]         in_ready;
  logic [NUM_CH*DATA_W-1:0]  in_data;
  logic [NUM_CH-1:0]         in_sop;
  logic [NUM_CH-1:0]         in_eop;
  logic [NUM_CH*EMPTY_W-1:0] in_empty;
  logic [NUM_CH-1:0]         out_valid;
  logic [NUM_CH-1:0]         out_ready;
  logic [NUM_CH*DATA_W-1:0]  out_data;
  logic [NUM_CH-1:0]         out_sop;
  logic [NUM_CH-1:0]         out_eop;
  logic [NUM_CH*EMPTY_W-1:0] out_empty;
  logic [NUM_CH-1:0]         frame_err;
  logic                      err_clear;
`ifdef HYPER_PIPE_STREAM_STATS_EN
  logic                      stat_clear;
  logic [NUM_CH*CNT_W-1:0]   stat_beats;
  logic [NUM_CH*CNT_W-1:0]   stat_pkts;
  logic [NUM_CH*CNT_W-1:0]   stat_stalls;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  word_t sent_q [NUM_CH][$];
  int    sent_t [NUM_CH][$];
  word_t recv_q [NUM_CH][$];
  int    recv_t [NUM_CH][$];

  always #5 clk = ~clk;

  hyper_pipe_stream #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .EMPTY_W    (EMPTY_W),
`ifdef HYPER_PIPE_STREAM_STATS_EN
    .CNT_W      (CNT_W),
`endif
    .NUM_STAGES (NUM_STAGES)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .in_sop_i      (in_sop),
    .in_eop_i      (in_eop),
    .in_empty_i    (in_empty),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_sop_o     (out_sop),
    .out_eop_o     (out_eop),
    .out_empty_o   (out_empty),
    .err_clear_i   (err_clear),
`ifdef HYPER_PIPE_STREAM_STATS_EN
    .stat_clear_i  (stat_clear),
    .stat_beats_o  (stat_beats),
    .stat_pkts_o   (stat_pkts),
    .stat_stalls_o (stat_stalls),
`endif
    .frame_err_o   (frame_err)
  );

  function automatic word_t in_word(int ch);
    return {in_sop[ch], in_eop[ch], in_empty[ch*EMPTY_W +: EMPTY_W], in_data[ch*DATA_W +: DATA_W]};
  endfunction

  function automatic word_t out_word(int ch);
    return {out_sop[ch], out_eop[ch], out_empty[ch*EMPTY_W +: EMPTY_W], out_data[ch*DATA_W +: DATA_W]};
  endfunction

  task automatic set_beat(int ch, logic sop, logic eop, logic [DATA_W-1:0] d, logic [EMPTY_W-1:0] e);
    in_sop[ch]                     = sop;
    in_eop[ch]                     = eop;
    in_data[ch*DATA_W +: DATA_W]   = d;
    in_empty[ch*EMPTY_W +: EMPTY_W] = e;
  endtask

  task automatic new_beat(int ch);
    set_beat(ch, 1'b1, 1'b1, DATA_W'($urandom), EMPTY_W'($urandom));
  endtask

  // Called at a falling edge with inputs already driven: logs every transfer
  // that the next rising edge will perform, then advances one cycle.
  task automatic tick();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (in_valid[ch] && in_ready[ch]) begin
        sent_q[ch].push_back(in_word(ch));
        sent_t[ch].push_back(cyc);
      end
      if (out_valid[ch] && out_ready[ch]) begin
        recv_q[ch].push_back(out_word(ch));
        recv_t[ch].push_back(cyc);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_q();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sent_q[ch].delete();
      sent_t[ch].delete();
      recv_q[ch].delete();
      recv_t[ch].delete();
    end
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = '1;
    repeat (4 * NUM_STAGES + 4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0; out_ready = '1; err_clear = 1'b0;
    in_data = '0; in_sop = '0; in_eop = '0; in_empty = '0;
`ifdef HYPER_PIPE_STREAM_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== '0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (frame_err !== '0) begin
      n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== '1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1111", in_ready);
    end
`ifdef HYPER_PIPE_STREAM_STATS_EN
    n_checks++;
    if (stat_beats !== '0 || stat_pkts !== '0 || stat_stalls !== '0) begin
      n_fail++; $display("FAIL reset_stats: got nonzero expected 0");
    end
`endif
  endtask

  task automatic test_single_beat_stream();
    clear_q();
    out_ready = '1;
    in_valid  = '1;
    for (int k = 0; k < 20; k++) begin
      for (int ch = 0; ch < NUM_CH; ch++) set_beat(ch, 1'b1, 1'b1, DATA_W'(k * NUM_CH + ch), EMPTY_W'(k));
      tick();
    end
    drain();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      n_checks++;
      if (sent_q[ch].size() !== 20 || recv_q[ch].size() !== 20) begin
        n_fail++;
        $display("FAIL stream_count ch%0d: sent %0d recv %0d expected 20", ch, sent_q[ch].size(), recv_q[ch].size());
      end
      for (int i = 0; i < recv_q[ch].size() && i < sent_q[ch].size(); i++) begin
        n_checks++;
        if (recv_q[ch][i] !== sent_q[ch][i]) begin
          n_fail++; $display("FAIL stream_data ch%0d beat%0d: got %h expected %h", ch, i, recv_q[ch][i], sent_q[ch][i]);
        end
        n_checks++;
        if (recv_t[ch][i] - sent_t[ch][i] !== NUM_STAGES) begin
          n_fail++; $display("FAIL stream_latency ch%0d beat%0d: got %0d expected %0d", ch, i, recv_t[ch][i] - sent_t[ch][i], NUM_STAGES);
        end
      end
    end
    n_checks++;
    if (frame_err !== '0) begin
      n_fail++; $display("FAIL stream_frame_err: got %b expected 0", frame_err);
    end
  endtask

  task automatic test_backpressure_ch1();
    int n1;
    int loops;
    logic [NUM_CH-1:0] fired;
    clear_q();
    n1 = 0; loops = 0;
    out_ready = '1;
    for (int ch = 0; ch < NUM_CH; ch++) new_beat(ch);
    in_valid = '1;
    while (n1 < 1000 && loops < 6000) begin
      out_ready[1] = 1'($urandom_range(0, 1));
      fired = in_valid & in_ready;
      if (fired[1]) n1++;
      tick();
      loops++;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (fired[ch]) begin
          if (ch == 1 && n1 == 1000) in_valid[1] = 1'b0;
          else new_beat(ch);
        end
      end
    end
    drain();
    n_checks++;
    if (n1 !== 1000) begin
      n_fail++; $display("FAIL bp_timeout: accepted %0d expected 1000", n1);
    end
    n_checks++;
    if (recv_q[1].size() !== 1000) begin
      n_fail++; $display("FAIL bp_ch1_count: got %0d expected 1000", recv_q[1].size());
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (ch != 1) begin
        n_checks++;
        if (sent_q[ch].size() !== loops || recv_q[ch].size() !== loops) begin
          n_fail++;
          $display("FAIL bp_other_rate ch%0d: sent %0d recv %0d expected %0d", ch, sent_q[ch].size(), recv_q[ch].size(), loops);
        end
      end
      for (int i = 0; i < recv_q[ch].size() && i < sent_q[ch].size(); i++) begin
        n_checks++;
        if (recv_q[ch][i] !== sent_q[ch][i]) begin
          n_fail++; $display("FAIL bp_data ch%0d beat%0d: got %h expected %h", ch, i, recv_q[ch][i], sent_q[ch][i]);
        end
      end
    end
  endtask

  task automatic test_stall_capacity();
    logic [NUM_CH-1:0] fired;
    int seq;
    clear_q();
    seq = 0;
    out_ready = '0;
    for (int ch = 0; ch < NUM_CH; ch++) set_beat(ch, 1'b1, 1'b1, DATA_W'(seq++), '0);
    in_valid = '1;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          n_checks++;
          if (sent_q[ch].size() !== 2 * NUM_STAGES) begin
            n_fail++; $display("FAIL stall_accepted ch%0d: got %0d expected %0d", ch, sent_q[ch].size(), 2 * NUM_STAGES);
          end
        end
        n_checks++;
        if (in_ready !== '0) begin
          n_fail++; $display("FAIL stall_in_ready: got %b expected 0000", in_ready);
        end
        out_ready = '1;
      end
      fired = in_valid & in_ready;
      tick();
      for (int ch = 0; ch < NUM_CH; ch++)
        if (fired[ch]) set_beat(ch, 1'b1, 1'b1, DATA_W'(seq++), '0);
    end
    drain();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      n_checks++;
      if (!(sent_q[ch].size() > 2 * NUM_STAGES) || recv_q[ch].size() !== sent_q[ch].size()) begin
        n_fail++; $display("FAIL stall_resume ch%0d: sent %0d recv %0d expected more than 4 and equal", ch, sent_q[ch].size(), recv_q[ch].size());
      end
      for (int i = 0; i < recv_q[ch].size() && i < sent_q[ch].size(); i++) begin
        n_checks++;
        if (recv_q[ch][i] !== sent_q[ch][i]) begin
          n_fail++; $display("FAIL stall_data ch%0d beat%0d: got %h expected %h", ch, i, recv_q[ch][i], sent_q[ch][i]);
        end
      end
    end
  endtask

  task automatic test_frame_err();
    clear_q();
    out_ready = '1;
    in_valid  = 4'b0100;
    set_beat(2, 1'b1, 1'b0, DATA_W'(32'hA0), '0); tick();
    set_beat(2, 1'b0, 1'b0, DATA_W'(32'hA1), '0); tick();
    n_checks++;
    if (frame_err !== '0) begin
      n_fail++; $display("FAIL frame_before_err: got %b expected 0000", frame_err);
    end
    set_beat(2, 1'b1, 1'b0, DATA_W'(32'hA2), '0); tick();
    n_checks++;
    if (frame_err !== 4'b0100) begin
      n_fail++; $display("FAIL frame_err_set: got %b expected 0100", frame_err);
    end
    in_valid  = '0;
    err_clear = 1'b1; tick();
    err_clear = 1'b0;
    n_checks++;
    if (frame_err !== '0) begin
      n_fail++; $display("FAIL frame_err_clear: got %b expected 0000", frame_err);
    end
    in_valid = 4'b0100;
    set_beat(2, 1'b0, 1'b1, DATA_W'(32'hA3), '0); tick();
    in_valid = '0;
    n_checks++;
    if (frame_err !== '0) begin
      n_fail++; $display("FAIL frame_legal_eop: got %b expected 0000", frame_err);
    end
    drain();
  endtask

  task automatic test_reset_mid_packet();
    clear_q();
    out_ready = '0;
    in_valid  = 4'b0001;
    set_beat(0, 1'b1, 1'b0, DATA_W'(32'hB0), '0); tick();
    set_beat(0, 1'b0, 1'b0, DATA_W'(32'hB1), '0); tick();
    set_beat(0, 1'b0, 1'b0, DATA_W'(32'hB2), '0); tick();
    n_checks++;
    if (out_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_inflight: got %b expected 1", out_valid[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== '0) begin
      n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0000", out_valid);
    end
    in_valid = '0;
    @(negedge clk);
    clear_q();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== '1) begin
      n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1111", in_ready);
    end
    out_ready = '1;
    in_valid  = 4'b0001;
    set_beat(0, 1'b0, 1'b1, DATA_W'(32'hB3), '0); tick();
    in_valid = '0;
    n_checks++;
    if (frame_err !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_no_sop_err: got %b expected 0001", frame_err);
    end
    drain();
    n_checks++;
    if (recv_q[0].size() !== 1 || sent_q[0].size() !== 1) begin
      n_fail++; $display("FAIL rstmid_discard: recv %0d sent %0d expected 1", recv_q[0].size(), sent_q[0].size());
    end else begin
      n_checks++;
      if (recv_q[0][0] !== sent_q[0][0]) begin
        n_fail++; $display("FAIL rstmid_data: got %h expected %h", recv_q[0][0], sent_q[0][0]);
      end
    end
    err_clear = 1'b1; tick(); err_clear = 1'b0;
  endtask

`ifdef HYPER_PIPE_STREAM_STATS_EN
  task automatic test_stats();
    int k;
    int stalls;
    int loops;
    logic fired;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    clear_q();
    k = 0; stalls = 0; loops = 0;
    out_ready = 4'b1110;
    in_valid  = 4'b0001;
    set_beat(0, 1'b1, 1'b0, DATA_W'(0), '0);
    while (recv_q[0].size() < 15 && loops < 500) begin
      if (out_valid[0] && !out_ready[0]) stalls++;
      fired = in_valid[0] & in_ready[0];
      tick();
      loops++;
      if (stalls == 7) out_ready[0] = 1'b1;
      if (fired) begin
        k++;
        if (k == 15) in_valid[0] = 1'b0;
        else set_beat(0, (k % 3) == 0, (k % 3) == 2, DATA_W'(k), '0);
      end
    end
    out_ready = '1;
    tick();
    n_checks++;
    if (stat_beats[0 +: CNT_W] !== CNT_W'(15)) begin
      n_fail++; $display("FAIL stat_beats: got %0d expected 15", stat_beats[0 +: CNT_W]);
    end
    n_checks++;
    if (stat_pkts[0 +: CNT_W] !== CNT_W'(5)) begin
      n_fail++; $display("FAIL stat_pkts: got %0d expected 5", stat_pkts[0 +: CNT_W]);
    end
    n_checks++;
    if (stat_stalls[0 +: CNT_W] !== CNT_W'(7)) begin
      n_fail++; $display("FAIL stat_stalls: got %0d expected 7", stat_stalls[0 +: CNT_W]);
    end
    n_checks++;
    if (stat_beats[NUM_CH*CNT_W-1:CNT_W] !== '0 || stat_pkts[NUM_CH*CNT_W-1:CNT_W] !== '0) begin
      n_fail++; $display("FAIL stat_idle_channels: got nonzero expected 0");
    end
    n_checks++;
    if (frame_err !== '0) begin
      n_fail++; $display("FAIL stat_frame_err: got %b expected 0000", frame_err);
    end
    stat_clear = 1'b1; tick(); stat_clear = 1'b0;
    n_checks++;
    if (stat_beats !== '0 || stat_pkts !== '0 || stat_stalls !== '0) begin
      n_fail++; $display("FAIL stat_clear: got nonzero expected 0");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat_stream();
    test_backpressure_ch1();
    test_stall_capacity();
    test_frame_err();
    test_reset_mid_packet();
`ifdef HYPER_PIPE_STREAM_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
